// File: rtl/universal_shift_register_pkg.sv
// Shared mode encodings for the universal shift register.
// The link serializer FSMs import the same names.
package universal_shift_register_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

endpackage

// File: rtl/universal_shift_register_counter.sv
// Modulo-WIDTH shift counter with a registered one-cycle wrap strobe.
// Clear has priority over increment.
module shift_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] r_count;
  logic             r_wrap;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (inc) begin
      if (r_count == LAST) begin
        r_count <= '0;
        r_wrap  <= 1'b1;
      end else begin
        r_count <= r_count + 1'b1;
        r_wrap  <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;

endmodule

// File: rtl/universal_shift_register.sv
// Eight-mode universal shift register with shift counter
// and word-complete strobe.
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in_p,
  input  logic             data_in_s,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out_msb,
  output logic             serial_out_lsb,
  output logic [CNT_W-1:0] shift_count,
  output logic             word_done
);

  import universal_shift_register_pkg::*;

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_next;
  logic             w_inc;
  logic             w_clr;

  always_comb begin
    w_next = r_data;
    w_inc  = 1'b0;
    w_clr  = 1'b0;
    case (mode)
      MODE_HOLD: w_next = r_data;
      MODE_SHL: begin
        w_next = {r_data[WIDTH-2:0], data_in_s};
        w_inc  = 1'b1;
      end
      MODE_SHR: begin
        w_next = {data_in_s, r_data[WIDTH-1:1]};
        w_inc  = 1'b1;
      end
      MODE_LOAD: begin
        w_next = data_in_p;
        w_clr  = 1'b1;
      end
      MODE_ROL: begin
        w_next = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
        w_inc  = 1'b1;
      end
      MODE_ROR: begin
        w_next = {r_data[0], r_data[WIDTH-1:1]};
        w_inc  = 1'b1;
      end
      MODE_ASR: begin
        w_next = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
        w_inc  = 1'b1;
      end
      MODE_CLR: begin
        w_next = '0;
        w_clr  = 1'b1;
      end
      default: w_next = r_data;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_data <= '0;
    else        r_data <= w_next;
  end

  shift_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (w_inc),
    .clr   (w_clr),
    .count (shift_count),
    .wrap  (word_done)
  );

  assign data_out       = r_data;
  assign serial_out_msb = r_data[WIDTH-1];
  assign serial_out_lsb = r_data[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench for universal_shift_register at WIDTH 8, 2 and 32.
// Stimulus pushes expectations; a monitor pops and compares after each edge.
module tb_universal_shift_register;

  import universal_shift_register_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        sin = 1'b0;
  logic [2:0]  m0 = MODE_HOLD;
  logic [2:0]  m1 = MODE_HOLD;
  logic [2:0]  m2 = MODE_HOLD;
  logic [7:0]  p0 = '0;
  logic [1:0]  p1 = '0;
  logic [31:0] p2 = '0;

  logic [7:0]  d0;
  logic [1:0]  d1;
  logic [31:0] d2;
  logic [2:0]  c0;
  logic [0:0]  c1;
  logic [4:0]  c2;
  logic        ms0, ms1, ms2, ls0, ls1, ls2, wd0, wd1, wd2;

  universal_shift_register #(.WIDTH(8)) u_w8 (
    .clock(clock), .reset(reset), .mode(m0), .data_in_p(p0),
    .data_in_s(sin), .data_out(d0), .serial_out_msb(ms0),
    .serial_out_lsb(ls0), .shift_count(c0), .word_done(wd0)
  );

  universal_shift_register #(.WIDTH(2)) u_w2 (
    .clock(clock), .reset(reset), .mode(m1), .data_in_p(p1),
    .data_in_s(sin), .data_out(d1), .serial_out_msb(ms1),
    .serial_out_lsb(ls1), .shift_count(c1), .word_done(wd1)
  );

  universal_shift_register #(.WIDTH(32)) u_w32 (
    .clock(clock), .reset(reset), .mode(m2), .data_in_p(p2),
    .data_in_s(sin), .data_out(d2), .serial_out_msb(ms2),
    .serial_out_lsb(ls2), .shift_count(c2), .word_done(wd2)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          id;
    int          tag;
    logic [63:0] d;
    int          c;
    logic        wd;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   tag_n = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  // Monitor: samples 2 time units after each rising edge
  exp_t        me;
  logic [63:0] a_d;
  logic [63:0] a_c;
  logic        a_wd, a_ms, a_ls;
  int          msb_i;
  always @(posedge clock) begin
    #2;
    if (sb.size() > 0) begin
      me = sb.pop_front();
      case (me.id)
        0: begin
          a_d = 64'(d0); a_c = 64'(c0); a_wd = wd0;
          a_ms = ms0; a_ls = ls0; msb_i = 7;
        end
        1: begin
          a_d = 64'(d1); a_c = 64'(c1); a_wd = wd1;
          a_ms = ms1; a_ls = ls1; msb_i = 1;
        end
        default: begin
          a_d = 64'(d2); a_c = 64'(c2); a_wd = wd2;
          a_ms = ms2; a_ls = ls2; msb_i = 31;
        end
      endcase
      chk($sformatf("data[w%0d#%0d]", me.id, me.tag), a_d, me.d);
      chk($sformatf("count[w%0d#%0d]", me.id, me.tag), a_c, 64'(me.c));
      chk($sformatf("word_done[w%0d#%0d]", me.id, me.tag),
          64'(a_wd), 64'(me.wd));
      chk($sformatf("msb[w%0d#%0d]", me.id, me.tag),
          64'(a_ms), (me.d >> msb_i) & 64'd1);
      chk($sformatf("lsb[w%0d#%0d]", me.id, me.tag),
          64'(a_ls), me.d & 64'd1);
    end
  end

  task automatic step(input int id, input logic [2:0] md,
                      input logic [63:0] p, input logic s,
                      input logic [63:0] ed, input int ec,
                      input logic ewd);
    exp_t e;
    m0 = MODE_HOLD;
    m1 = MODE_HOLD;
    m2 = MODE_HOLD;
    sin = s;
    case (id)
      0: begin m0 = md; p0 = p[7:0]; end
      1: begin m1 = md; p1 = p[1:0]; end
      default: begin m2 = md; p2 = p[31:0]; end
    endcase
    e.id = id;
    e.tag = tag_n;
    e.d = ed;
    e.c = ec;
    e.wd = ewd;
    tag_n++;
    sb.push_back(e);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic serialize(input int id, input int w,
                           input logic [63:0] init);
    logic [63:0] mask;
    logic [63:0] d;
    logic        s;
    mask = (64'd1 << w) - 64'd1;
    d = init & mask;
    step(id, MODE_LOAD, d, 1'b0, d, 0, 1'b0);
    for (int i = 1; i <= 3 * w; i++) begin
      s = i[1];
      d = ((d << 1) | 64'(s)) & mask;
      step(id, MODE_SHL, '0, s, d, i % w, (i % w) == 0);
    end
    step(id, MODE_HOLD, '0, 1'b0, d, 0, 1'b0);
  endtask

  logic [7:0] shl_exp [8] = '{8'h4A, 8'h94, 8'h28, 8'h50,
                              8'hA0, 8'h40, 8'h80, 8'h00};
  logic [7:0] shr_exp [8] = '{8'h80, 8'hC0, 8'h60, 8'h30,
                              8'h98, 8'h4C, 8'hA6, 8'h53};
  logic       shr_in  [8] = '{1, 1, 0, 0, 1, 0, 1, 0};
  logic [7:0] sh5_exp [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F};

  initial begin
    #1;
    chk("reset_data_w8", 64'(d0), 64'd0);
    chk("reset_count_w8", 64'(c0), 64'd0);
    chk("reset_wd_w8", 64'(wd0), 64'd0);
    chk("reset_data_w32", 64'(d2), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Left serialize A5
    step(0, MODE_LOAD, 64'hA5, 1'b0, 64'hA5, 0, 1'b0);
    for (int i = 0; i < 8; i++)
      step(0, MODE_SHL, '0, 1'b0, 64'(shl_exp[i]), (i + 1) % 8, i == 7);
    step(0, MODE_HOLD, '0, 1'b0, 64'h00, 0, 1'b0);

    // Right deserialize from clear
    step(0, MODE_CLR, '0, 1'b0, 64'h00, 0, 1'b0);
    for (int i = 0; i < 8; i++)
      step(0, MODE_SHR, '0, shr_in[i], 64'(shr_exp[i]), (i + 1) % 8,
           i == 7);
    step(0, MODE_SHR, '0, 1'b0, 64'h29, 1, 1'b0);

    // Rotate and arithmetic shift
    step(0, MODE_LOAD, 64'h81, 1'b0, 64'h81, 0, 1'b0);
    step(0, MODE_ROL, '0, 1'b1, 64'h03, 1, 1'b0);
    step(0, MODE_ROR, '0, 1'b0, 64'h81, 2, 1'b0);
    step(0, MODE_ROR, '0, 1'b0, 64'hC0, 3, 1'b0);
    step(0, MODE_ASR, '0, 1'b0, 64'hE0, 4, 1'b0);

    // Mid-word hold then load
    step(0, MODE_CLR, '0, 1'b0, 64'h00, 0, 1'b0);
    for (int i = 0; i < 5; i++)
      step(0, MODE_SHL, '0, 1'b1, 64'(sh5_exp[i]), i + 1, 1'b0);
    for (int i = 0; i < 3; i++)
      step(0, MODE_HOLD, '0, 1'b1, 64'h1F, 5, 1'b0);
    step(0, MODE_LOAD, 64'h3C, 1'b0, 64'h3C, 0, 1'b0);
    step(0, MODE_HOLD, '0, 1'b0, 64'h3C, 0, 1'b0);

    // Reset during activity
    step(0, MODE_LOAD, 64'hA5, 1'b0, 64'hA5, 0, 1'b0);
    step(0, MODE_SHL, '0, 1'b0, 64'h4A, 1, 1'b0);
    step(0, MODE_SHL, '0, 1'b0, 64'h94, 2, 1'b0);
    step(0, MODE_SHL, '0, 1'b0, 64'h28, 3, 1'b0);
    m0 = MODE_SHL;
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_data", 64'(d0), 64'd0);
    chk("async_rst_count", 64'(c0), 64'd0);
    chk("async_rst_wd", 64'(wd0), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #2;
      chk("rst_held_data", 64'(d0), 64'd0);
      chk("rst_held_wd", 64'(wd0), 64'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 7; i++)
      step(0, MODE_SHL, '0, 1'b0, 64'h00, i + 1, 1'b0);
    step(0, MODE_HOLD, '0, 1'b0, 64'h00, 7, 1'b0);

    // Parametrised widths, three continuous words each
    serialize(1, 2, 64'h2);
    serialize(2, 32, 64'hA5A5_0F0F);

    repeat (4) begin
      if (sb.size() > 0) @(negedge clock);
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised, eight-mode universal shift register with a built-in shift counter and a word-complete strobe. It is the next generation of the team's 8-bit shift register. It is used as the serializer and deserializer core in the FPGA-to-FPGA link, and as a general-purpose shifter in the datapath. Over the old block it adds width generalisation, rotate, arithmetic-shift and clear modes, serial-out taps and per-word framing.

## Interface

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), width of shift_count.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- mode  in  3  operation select; encoding under Operation.
- data_in_p  in  WIDTH  parallel load data.
- data_in_s  in  1  serial input bit.
- data_out  out  WIDTH  register contents.
- serial_out_msb  out  1  always equals data_out[WIDTH-1]; this is the bit leaving on a left shift.
- serial_out_lsb  out  1  always equals data_out[0]; this is the bit leaving on a right shift.
- shift_count  out  CNT_W  number of counted operations since the last load, clear or wrap.
- word_done  out  1  one-cycle registered strobe marking a completed word.

## Operation

Mode encoding:
- 000 hold: register unchanged.
- 001 shift left: data_out becomes {data_out[WIDTH-2:0], data_in_s}.
- 010 shift right: data_out becomes {data_in_s, data_out[WIDTH-1:1]}.
- 011 load: data_out becomes data_in_p.
- 100 rotate left: data_out becomes {data_out[WIDTH-2:0], data_out[WIDTH-1]}.
- 101 rotate right: data_out becomes {data_out[0], data_out[WIDTH-1:1]}.
- 110 arithmetic shift right: data_out becomes {data_out[WIDTH-1], data_out[WIDTH-1:1]}. data_in_s is ignored.
- 111 clear: data_out becomes 0.

Counter rules:
- Counted modes are 001, 010, 100, 101 and 110. Each one increments shift_count by 1.
- When a counted mode occurs with shift_count == WIDTH-1:
  - shift_count wraps to 0;
  - word_done is set to 1 for exactly one cycle.
- Load (011) and clear (111) force shift_count to 0 and word_done to 0. This applies whatever the prior count.
- Hold (000) leaves shift_count unchanged and drives word_done to 0.
- In every cycle except a wrap, word_done is 0.
- Back-to-back words need no idle cycle. After a wrap, the next counted operation counts as 1 of the new word.

Reset:
- While reset is 0, data_out, shift_count and word_done are all 0, immediately and without waiting for a clock edge.
- Reset asserted mid-word aborts the word. No word_done is produced for the partial word.

## Timing

- data_out, shift_count and word_done are registers. The new value is visible after the rising edge at which mode is sampled, so latency is 1 cycle.
- serial_out_msb and serial_out_lsb are combinational taps of data_out. They add no latency and carry no extra logic.
- word_done is high in the cycle immediately after the WIDTH-th counted edge.
  - With continuous shifting, word_done pulses once every WIDTH cycles.
- Reset deassertion must be synchronised outside the block. The first update occurs on the first rising edge with reset at 1.
- mode, data_in_p and data_in_s must be stable around the rising edge. There is no input registering.

## Structure

- The mode encodings go in a shared package/header, shift_modes.vh, as named localparams: MODE_HOLD, MODE_SHL, MODE_SHR, MODE_LOAD, MODE_ROL, MODE_ROR, MODE_ASR, MODE_CLR. These are reused by the link serializer FSMs.
- Sub-module shift_counter(clock, reset, inc, clr, count, wrap) holds the modulo-WIDTH counter and wrap strobe, parametrised on WIDTH.
- The top level holds the data register and the mode decode. Decode is a full case with a default of hold.

## Test plan

- Reset during activity: with WIDTH=8, load 8'hA5, shift left 3 times, then pull reset low between clock edges. Required: data_out=0, shift_count=0 and word_done=0 immediately; word_done never pulses afterward.
- Left serialize: load 8'hA5 (1010_0101), then 8 consecutive shift-left with data_in_s=0. Required:
  - serial_out_msb sequence, sampled before each shift, is 1,0,1,0,0,1,0,1;
  - after the 8th edge, data_out=8'h00, shift_count=0, and word_done=1 for one cycle only.
- Right deserialize: from clear, 8 shift-right with data_in_s stream 1,1,0,0,1,0,1,0. Required: data_out=8'h53 and word_done pulses once; a 9th shift gives shift_count=1 and word_done=0.
- Rotate and arithmetic: load 8'h81, then:
  - rotate left gives 8'h03;
  - rotate right twice gives 8'hC0;
  - arithmetic shift right gives 8'hE0.
  Required: shift_count reads 1, 2, 3, 4 after each of these four operations.
- Mid-word load and hold: shift 5 times, hold 3 cycles (shift_count stays 5), then load 8'h3C. Required: shift_count=0, data_out=8'h3C and no word_done.
- Parametrisation: repeat the left-serialize scenario with WIDTH=2 and WIDTH=32. Required: word_done pulses every WIDTH counted shifts during 3 continuous words, with no idle gaps.
